// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: request/result handshake bundle for shift_seq_ctrl.
// Carries the ovf flag only when SHIFT_OVF_EN is defined.
interface shift_seq_ctrl_if #(parameter int WIDTH = 4, parameter int AMT_W = 3);
   logic             i_in_valid;
   logic             o_in_ready;
   logic [WIDTH-1:0] i_in;
   logic [1:0]       i_sel;
   logic [AMT_W-1:0] i_amt;
   logic             o_out_valid;
   logic             i_out_ready;
   logic [WIDTH-1:0] o_out;
   logic             o_busy;
`ifdef SHIFT_OVF_EN
   logic             o_ovf;
   modport master(output i_in_valid, i_in, i_sel, i_amt, i_out_ready,
                  input o_in_ready, o_out_valid, o_out, o_busy, o_ovf);
   modport slave(input i_in_valid, i_in, i_sel, i_amt, i_out_ready,
                 output o_in_ready, o_out_valid, o_out, o_busy, o_ovf);
`else
   modport master(output i_in_valid, i_in, i_sel, i_amt, i_out_ready,
                  input o_in_ready, o_out_valid, o_out, o_busy);
   modport slave(input i_in_valid, i_in, i_sel, i_amt, i_out_ready,
                 output o_in_ready, o_out_valid, o_out, o_busy);
`endif
endinterface

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle LSL/LSR/ASL/ASR sequencer, one 1-bit shift per clock.
// SHIFT_OVF_EN adds a sticky overflow flag of all bits shifted out.
module shift_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input logic             clk,
   input logic             rst,
   shift_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_work, r_out, w_shifted;
   logic [1:0]       r_sel;
   logic [CW-1:0]    r_cnt, w_n;
   logic             w_accept, w_last;
`ifdef SHIFT_OVF_EN
   logic             r_ovf, w_lost;
   assign w_lost = r_sel[0] ? r_work[0] : r_work[WIDTH-1];
`endif
   assign w_accept  = bus.i_in_valid & bus.o_in_ready;
   assign w_n       = (32'(bus.i_amt) >= WIDTH) ? CW'(WIDTH) : CW'(bus.i_amt);
   assign w_last    = r_cnt == CW'(1);
   assign w_shifted = r_sel[0] ? {r_sel[1] & r_work[WIDTH-1], r_work[WIDTH-1:1]}
                               : {r_work[WIDTH-2:0], 1'b0};
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   always_comb begin
      w_next = (r_state == IDLE)  ? (w_accept ? ((w_n == '0) ? DONE : SHIFT) : IDLE) :
               (r_state == SHIFT) ? (w_last ? DONE : SHIFT) :
               (r_state == DONE && !bus.i_out_ready) ? DONE : IDLE;
   end
   always_comb begin
      bus.o_in_ready  = (r_state == IDLE) & ~rst;
      bus.o_busy      = r_state != IDLE;
      bus.o_out_valid = r_state == DONE;
      bus.o_out       = r_out;
`ifdef SHIFT_OVF_EN
      bus.o_ovf       = r_ovf;
`endif
   end
   // r_out only changes on entry to DONE, so it stays put through DONE and after
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work <= '0;
         r_sel  <= '0;
         r_cnt  <= '0;
         r_out  <= '0;
`ifdef SHIFT_OVF_EN
         r_ovf  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_work <= bus.i_in;
         r_sel  <= bus.i_sel;
         r_cnt  <= w_n;
         if (w_n == '0) r_out <= bus.i_in;
`ifdef SHIFT_OVF_EN
         r_ovf  <= 1'b0;
`endif
      end else if (r_state == SHIFT) begin
         r_work <= w_shifted;
         r_cnt  <= r_cnt - CW'(1);
         if (w_last) r_out <= w_shifted;
`ifdef SHIFT_OVF_EN
         r_ovf  <= r_ovf | w_lost;
`endif
      end
   end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed and random requests checked against an arithmetic shift model.
module tb_shift_seq_ctrl;
   localparam int W  = 4;
   localparam int AW = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   shift_seq_ctrl_if #(.WIDTH(W), .AMT_W(AW)) bus ();
   shift_seq_ctrl #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   function automatic int eff(input int a);
      return (a > W) ? W : a;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] s, input int a);
      logic signed [W-1:0] sd = d;
      int n = eff(a);
      case (s)
         2'b01:   return d >> n;
         2'b11:   return sd >>> n;
         default: return d << n;
      endcase
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] d, input logic [1:0] s, input int a);
      int n = eff(a);
      if (n == 0) return 1'b0;
      if (s[0]) return (int'(d) & ((1 << n) - 1)) != 0;
      return (int'(d) >> (W - n)) != 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [W-1:0] d, input logic [1:0] s, input logic [AW-1:0] a,
                        input int hold, input string tag);
      logic [W-1:0] exp = model(d, s, int'(a));
      int lat;
      @(negedge clk);
      bus.i_in_valid = 1'b1;
      bus.i_in = d;
      bus.i_sel = s;
      bus.i_amt = a;
      for (lat = 0; lat < 20 && !bus.o_in_ready; lat++) @(negedge clk);
      check({tag, "_in_ready"}, 32'(bus.o_in_ready), 1);
      @(negedge clk);
      bus.i_in_valid = 1'b0;
      bus.i_in = W'($urandom);
      bus.i_sel = 2'($urandom);
      bus.i_amt = AW'($urandom);
      for (lat = 1; lat < 20 && !bus.o_out_valid; lat++) @(negedge clk);
      check({tag, "_latency"}, 32'(lat), 32'(1 + eff(int'(a))));
      check({tag, "_out"}, 32'(bus.o_out), 32'(exp));
      check({tag, "_busy"}, 32'(bus.o_busy), 1);
      check({tag, "_in_ready_done"}, 32'(bus.o_in_ready), 0);
`ifdef SHIFT_OVF_EN
      check({tag, "_ovf"}, 32'(bus.o_ovf), 32'(model_ovf(d, s, int'(a))));
`endif
      for (int h = 0; h < hold; h++) begin
         bus.i_in_valid = 1'b1;
         bus.i_in = W'($urandom);
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(bus.o_out_valid), 1);
         check({tag, "_hold_out"}, 32'(bus.o_out), 32'(exp));
         check({tag, "_hold_in_ready"}, 32'(bus.o_in_ready), 0);
      end
      bus.i_in_valid = 1'b0;
      bus.i_out_ready = 1'b1;
      @(negedge clk);
      bus.i_out_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(bus.o_out_valid), 0);
      check({tag, "_post_in_ready"}, 32'(bus.o_in_ready), 1);
      check({tag, "_post_busy"}, 32'(bus.o_busy), 0);
      check({tag, "_post_out"}, 32'(bus.o_out), 32'(exp));
   endtask

   initial begin
      int seen;
      bus.i_in_valid = 1'b0;
      bus.i_in = '0;
      bus.i_sel = '0;
      bus.i_amt = '0;
      bus.i_out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(bus.o_out_valid), 0);
      check("rst_out", 32'(bus.o_out), 0);
      check("rst_busy", 32'(bus.o_busy), 0);
      check("rst_in_ready", 32'(bus.o_in_ready), 0);
      rst = 1'b0;
      #1;
      check("rst_release_in_ready", 32'(bus.o_in_ready), 1);
      do_op(4'b0110, 2'b00, 3'd1, 0, "lsl1");
      do_op(4'b1010, 2'b11, 3'd2, 1, "asr2");
      do_op(4'b0110, 2'b00, 3'd0, 0, "amt0_lsl");
      do_op(4'b0110, 2'b01, 3'd0, 0, "amt0_lsr");
      do_op(4'b0110, 2'b10, 3'd0, 2, "amt0_asl");
      do_op(4'b0110, 2'b11, 3'd0, 0, "amt0_asr");
      do_op(4'b1000, 2'b11, 3'd7, 3, "asr_clamp");
      do_op(4'b0110, 2'b00, 3'd2, 0, "lsl2");
      do_op(4'b0100, 2'b01, 3'd2, 0, "lsr2");
      do_op(4'b1010, 2'b01, 3'd2, 0, "lsr_pre_rst");
      @(negedge clk);
      bus.i_in_valid = 1'b1;
      bus.i_in = 4'b1000;
      bus.i_sel = 2'b11;
      bus.i_amt = 3'd4;
      @(negedge clk);
      bus.i_in_valid = 1'b0;
      check("mid_busy", 32'(bus.o_busy), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 32'(bus.o_in_ready), 0);
      @(negedge clk);
      check("mid_rst_out_valid", 32'(bus.o_out_valid), 0);
      check("mid_rst_out", 32'(bus.o_out), 0);
      check("mid_rst_busy", 32'(bus.o_busy), 0);
      rst = 1'b0;
      #1;
      check("mid_rst_in_ready_after", 32'(bus.o_in_ready), 1);
      bus.i_out_ready = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         seen += int'(bus.o_out_valid);
      end
      bus.i_out_ready = 1'b0;
      check("mid_rst_no_result", 32'(seen), 0);
      do_op(4'b0110, 2'b00, 3'd1, 0, "after_rst");
      for (int i = 0; i < 40; i++)
         do_op(W'($urandom), 2'($urandom), AW'($urandom), int'($urandom_range(0, 3)), "rand");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
